memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter MEM_DEPTH, default 256: data memory size in 32-bit words; SHALL be a power of two.
REQ-002 Port i_clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port i_reset  in  1  synchronous, active-high reset.
REQ-004 Ports i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned  in  1 each  control from the execute-stage pipeline register.
REQ-005 Port i_MEM_byte_half_word  in  2  access size: 00 byte, 01 half word, 11 word; 10 SHALL be treated as word.
REQ-006 Ports i_write_reg  in  5, i_ALU_result  in  32, i_data_to_write_in_MEM  in  32  destination register, byte address or ALU value, and store data.
REQ-007 Port i_debug_addr  in  log2(MEM_DEPTH)  word index for the debug read port.
REQ-008 Ports o_WB_write, o_WB_mem_to_reg  out  1 each; o_write_reg  out  5  registered pass-through to writeback.
REQ-009 Ports o_mem_data  out  32, o_ALU_result  out  32  registered load data and registered ALU value.
REQ-010 Port o_misaligned  out  1  registered flag for a rejected misaligned access.
REQ-011 Port o_debug_data  out  32  combinational word read at i_debug_addr.

Function
REQ-012 Memory SHALL be byte-addressed and little-endian; word index = i_ALU_result[log2(MEM_DEPTH)+1:2]; higher address bits SHALL be ignored (wrap modulo 4*MEM_DEPTH bytes).
REQ-013 Store (i_MEM_write=1): byte SHALL write lane i_ALU_result[1:0] with data[7:0]; half SHALL write lanes {addr[1],0} and {addr[1],1} with data[15:0]; word SHALL write all lanes. Write takes effect at the rising edge; unwritten lanes SHALL be preserved.
REQ-014 Load (i_MEM_read=1): addressed byte, half or word SHALL be selected from the current array contents, zero-extended when i_MEM_unsigned=1, otherwise sign-extended, and registered into o_mem_data; latency one cycle.
REQ-015 When i_MEM_read=0, o_mem_data SHALL load 0 on the clock edge.
REQ-016 Misaligned: half with addr[0]=1, or word with addr[1:0]!=00. A misaligned store SHALL NOT modify memory; a misaligned load SHALL register 0 into o_mem_data; o_misaligned SHALL be 1 for the following cycle, 0 otherwise.
REQ-017 i_MEM_read and i_MEM_write both 1: the store SHALL occur and the load SHALL return the pre-store contents.
REQ-018 o_WB_write, o_WB_mem_to_reg, o_write_reg, o_ALU_result SHALL register their inputs unmodified each cycle; latency one cycle.
REQ-019 o_debug_data SHALL return the full word at i_debug_addr combinationally; a same-cycle store to that word SHALL become visible after the clock edge.

Reset
REQ-020 While i_reset=1 at a clock edge, o_WB_write, o_WB_mem_to_reg, o_misaligned SHALL be 0, and o_write_reg, o_mem_data, o_ALU_result SHALL be 0.
REQ-021 While i_reset=1, stores SHALL be suppressed; memory contents SHALL otherwise be unaffected by reset.
REQ-022 After i_reset deasserts, the first active cycle SHALL behave as a normal access with no residual state.

Verification
REQ-023 Word store 0xDEADBEEF to addr 0x10, then word load from 0x10 -> o_mem_data=0xDEADBEEF one cycle after the load; o_debug_data at index 4 = 0xDEADBEEF.
REQ-024 With word 0xDEADBEEF at 0x10, signed byte load from 0x13 -> 0xFFFFFFDE; unsigned byte load from 0x13 -> 0x000000DE; signed half load from 0x10 -> 0xFFFFBEEF; unsigned half -> 0x0000BEEF.
REQ-025 Byte store 0x55 to 0x11 over 0xDEADBEEF -> word reads 0xDEAD55EF; half store 0x1234 to 0x12 -> word reads 0x123455EF.
REQ-026 Word store to 0x12 and half load from 0x11 -> memory unchanged, o_mem_data=0, o_misaligned=1 for exactly one cycle each.
REQ-027 Store to 0x10 with i_reset=1 -> memory unchanged, all registered outputs 0; store to address 0x400+0x10 with MEM_DEPTH=256 -> aliases to index 4.
REQ-028 Pass-through: i_write_reg=7, i_WB_write=1, i_ALU_result=0x100, i_MEM_read=0 -> next cycle o_write_reg=7, o_WB_write=1, o_ALU_result=0x100, o_mem_data=0.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage of the pipeline: byte-addressed little-endian data memory with sized,
// sign/zero-extending loads, lane-masked stores and registered writeback outputs.
module memory_access #(
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_WB_write,
  input  logic                         i_WB_mem_to_reg,
  input  logic                         i_MEM_read,
  input  logic                         i_MEM_write,
  input  logic                         i_MEM_unsigned,
  input  logic [1:0]                   i_MEM_byte_half_word,
  input  logic [4:0]                   i_write_reg,
  input  logic [31:0]                  i_ALU_result,
  input  logic [31:0]                  i_data_to_write_in_MEM,
  input  logic [$clog2(MEM_DEPTH)-1:0] i_debug_addr,
  output logic                         o_WB_write,
  output logic                         o_WB_mem_to_reg,
  output logic [4:0]                   o_write_reg,
  output logic [31:0]                  o_mem_data,
  output logic [31:0]                  o_ALU_result,
  output logic                         o_misaligned,
  output logic [31:0]                  o_debug_data
);

  localparam int unsigned AW = $clog2(MEM_DEPTH);

  logic [31:0]   mem_q [MEM_DEPTH];

  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic          is_byte;
  logic          is_half;
  logic          misaligned;
  logic          store_en;
  logic [3:0]    byte_en;
  logic [31:0]   wdata;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_val;
  logic          unused_addr_hi;

  // Address bits above the array wrap the access modulo the memory size.
  assign unused_addr_hi = ^i_ALU_result[31:AW+2];

  assign word_idx = i_ALU_result[AW+1:2];
  assign lane     = i_ALU_result[1:0];
  assign is_byte  = (i_MEM_byte_half_word == 2'b00);
  assign is_half  = (i_MEM_byte_half_word == 2'b01);
  assign rd_word  = mem_q[word_idx];

  always_comb begin
    misaligned = 1'b0;
    byte_en    = 4'b1111;
    wdata      = i_data_to_write_in_MEM;
    rd_byte    = rd_word[7:0];
    rd_half    = rd_word[15:0];
    load_val   = rd_word;

    if (i_MEM_read || i_MEM_write) begin
      if (is_half) begin
        misaligned = lane[0];
      end else if (!is_byte) begin
        misaligned = (lane != 2'b00);
      end
    end

    unique case (lane)
      2'd0: rd_byte = rd_word[7:0];
      2'd1: rd_byte = rd_word[15:8];
      2'd2: rd_byte = rd_word[23:16];
      2'd3: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    if (is_byte) begin
      byte_en  = 4'b0001 << lane;
      wdata    = {4{i_data_to_write_in_MEM[7:0]}};
      load_val = {{24{~i_MEM_unsigned & rd_byte[7]}}, rd_byte};
    end else if (is_half) begin
      byte_en  = lane[1] ? 4'b1100 : 4'b0011;
      wdata    = {2{i_data_to_write_in_MEM[15:0]}};
      load_val = {{16{~i_MEM_unsigned & rd_half[15]}}, rd_half};
    end
  end

  assign store_en = i_MEM_write && !misaligned && !i_reset;

  // Memory contents are deliberately not cleared by reset.
  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_WB_write      <= 1'b0;
      o_WB_mem_to_reg <= 1'b0;
      o_write_reg     <= '0;
      o_mem_data      <= '0;
      o_ALU_result    <= '0;
      o_misaligned    <= 1'b0;
    end else begin
      o_WB_write      <= i_WB_write;
      o_WB_mem_to_reg <= i_WB_mem_to_reg;
      o_write_reg     <= i_write_reg;
      o_ALU_result    <= i_ALU_result;
      o_misaligned    <= misaligned;
      o_mem_data      <= (i_MEM_read && !misaligned) ? load_val : 32'd0;
    end
  end

  assign o_debug_data = mem_q[i_debug_addr];

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: sized loads/stores, misalignment, reset and pass-through.
module tb_memory_access;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_WB_write, i_WB_mem_to_reg, i_MEM_read, i_MEM_write, i_MEM_unsigned;
  logic [1:0]  i_MEM_byte_half_word;
  logic [4:0]  i_write_reg;
  logic [31:0] i_ALU_result, i_data_to_write_in_MEM;
  logic [7:0]  i_debug_addr;
  logic        o_WB_write, o_WB_mem_to_reg, o_misaligned;
  logic [4:0]  o_write_reg;
  logic [31:0] o_mem_data, o_ALU_result, o_debug_data;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  memory_access #(.MEM_DEPTH(256)) dut (
    .i_clk                 (i_clk),
    .i_reset               (i_reset),
    .i_WB_write            (i_WB_write),
    .i_WB_mem_to_reg       (i_WB_mem_to_reg),
    .i_MEM_read            (i_MEM_read),
    .i_MEM_write           (i_MEM_write),
    .i_MEM_unsigned        (i_MEM_unsigned),
    .i_MEM_byte_half_word  (i_MEM_byte_half_word),
    .i_write_reg           (i_write_reg),
    .i_ALU_result          (i_ALU_result),
    .i_data_to_write_in_MEM(i_data_to_write_in_MEM),
    .i_debug_addr          (i_debug_addr),
    .o_WB_write            (o_WB_write),
    .o_WB_mem_to_reg       (o_WB_mem_to_reg),
    .o_write_reg           (o_write_reg),
    .o_mem_data            (o_mem_data),
    .o_ALU_result          (o_ALU_result),
    .o_misaligned          (o_misaligned),
    .o_debug_data          (o_debug_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One memory access: set controls, advance one clock, leave outputs ready to sample.
  task automatic acc(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                     input logic [31:0] addr, input logic [31:0] data);
    i_MEM_read             = rd;
    i_MEM_write            = wr;
    i_MEM_unsigned         = uns;
    i_MEM_byte_half_word   = sz;
    i_ALU_result           = addr;
    i_data_to_write_in_MEM = data;
    tick();
  endtask

  initial begin
    i_reset = 1'b1;
    i_WB_write = 1'b0; i_WB_mem_to_reg = 1'b0; i_write_reg = 5'd0;
    i_MEM_read = 1'b0; i_MEM_write = 1'b0; i_MEM_unsigned = 1'b0;
    i_MEM_byte_half_word = 2'b11; i_ALU_result = 32'd0; i_data_to_write_in_MEM = 32'd0;
    i_debug_addr = 8'd4;
    tick();
    tick();
    chk("reset_mem_data", o_mem_data, 32'd0);
    chk("reset_misaligned", {31'd0, o_misaligned}, 32'd0);
    chk("reset_wb_write", {31'd0, o_WB_write}, 32'd0);
    i_reset = 1'b0;

    acc(1'b0, 1'b1, 1'b0, 2'b11, 32'h10, 32'hDEADBEEF);
    chk("word_store_debug", o_debug_data, 32'hDEADBEEF);
    chk("store_no_read_data", o_mem_data, 32'd0);
    acc(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'd0);
    chk("word_load", o_mem_data, 32'hDEADBEEF);
    chk("word_load_aligned", {31'd0, o_misaligned}, 32'd0);
    acc(1'b1, 1'b0, 1'b0, 2'b10, 32'h10, 32'd0);
    chk("size10_as_word", o_mem_data, 32'hDEADBEEF);
    acc(1'b1, 1'b0, 1'b0, 2'b00, 32'h13, 32'd0);
    chk("byte_signed", o_mem_data, 32'hFFFFFFDE);
    acc(1'b1, 1'b0, 1'b1, 2'b00, 32'h13, 32'd0);
    chk("byte_unsigned", o_mem_data, 32'h000000DE);
    acc(1'b1, 1'b0, 1'b0, 2'b00, 32'h11, 32'd0);
    chk("byte_lane1_signed", o_mem_data, 32'hFFFFFFBE);
    acc(1'b1, 1'b0, 1'b0, 2'b01, 32'h10, 32'd0);
    chk("half_signed", o_mem_data, 32'hFFFFBEEF);
    acc(1'b1, 1'b0, 1'b1, 2'b01, 32'h10, 32'd0);
    chk("half_unsigned", o_mem_data, 32'h0000BEEF);
    acc(1'b1, 1'b0, 1'b0, 2'b01, 32'h12, 32'd0);
    chk("half_upper_signed", o_mem_data, 32'hFFFFDEAD);

    acc(1'b0, 1'b1, 1'b0, 2'b00, 32'h11, 32'h00000055);
    chk("byte_store", o_debug_data, 32'hDEAD55EF);
    acc(1'b0, 1'b1, 1'b0, 2'b01, 32'h12, 32'h00001234);
    chk("half_store", o_debug_data, 32'h123455EF);

    acc(1'b0, 1'b1, 1'b0, 2'b11, 32'h12, 32'hAAAAAAAA);
    chk("mis_store_mem", o_debug_data, 32'h123455EF);
    chk("mis_store_flag", {31'd0, o_misaligned}, 32'd1);
    acc(1'b0, 1'b0, 1'b0, 2'b11, 32'h10, 32'd0);
    chk("mis_flag_clears", {31'd0, o_misaligned}, 32'd0);
    acc(1'b1, 1'b0, 1'b0, 2'b01, 32'h11, 32'd0);
    chk("mis_load_data", o_mem_data, 32'd0);
    chk("mis_load_flag", {31'd0, o_misaligned}, 32'd1);
    acc(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'd0);
    chk("after_mis_load", o_mem_data, 32'h123455EF);
    chk("after_mis_flag", {31'd0, o_misaligned}, 32'd0);

    acc(1'b1, 1'b1, 1'b0, 2'b11, 32'h10, 32'hCAFEF00D);
    chk("rw_old_data", o_mem_data, 32'h123455EF);
    chk("rw_new_mem", o_debug_data, 32'hCAFEF00D);

    i_reset = 1'b1; i_WB_write = 1'b1; i_WB_mem_to_reg = 1'b1; i_write_reg = 5'd5;
    acc(1'b1, 1'b1, 1'b0, 2'b11, 32'h10, 32'h11111111);
    chk("rst_store_blocked", o_debug_data, 32'hCAFEF00D);
    chk("rst_mem_data", o_mem_data, 32'd0);
    chk("rst_wb_write", {31'd0, o_WB_write}, 32'd0);
    chk("rst_mem_to_reg", {31'd0, o_WB_mem_to_reg}, 32'd0);
    chk("rst_write_reg", {27'd0, o_write_reg}, 32'd0);
    chk("rst_alu", o_ALU_result, 32'd0);
    i_reset = 1'b0; i_WB_write = 1'b0; i_WB_mem_to_reg = 1'b0; i_write_reg = 5'd0;

    acc(1'b0, 1'b1, 1'b0, 2'b11, 32'h410, 32'h0BADC0DE);
    chk("alias_store", o_debug_data, 32'h0BADC0DE);
    acc(1'b1, 1'b0, 1'b0, 2'b11, 32'h10, 32'd0);
    chk("alias_load", o_mem_data, 32'h0BADC0DE);

    i_write_reg = 5'd7; i_WB_write = 1'b1; i_WB_mem_to_reg = 1'b1;
    acc(1'b0, 1'b0, 1'b0, 2'b11, 32'h100, 32'd0);
    chk("pt_write_reg", {27'd0, o_write_reg}, 32'd7);
    chk("pt_wb_write", {31'd0, o_WB_write}, 32'd1);
    chk("pt_mem_to_reg", {31'd0, o_WB_mem_to_reg}, 32'd1);
    chk("pt_alu", o_ALU_result, 32'h100);
    chk("pt_mem_data", o_mem_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
